// File: rtl/urv_trap_ctrl.sv
// ============================================================================
// urv_trap_ctrl
// ----------------------------------------------------------------------------
// Machine-mode trap controller for the uRV core. Owns mstatus, mie, mip,
// mepc and mcause. Decides when a synchronous exception or an interrupt is
// taken, sequences trap entry and MRET exit with the execute stage, and
// applies CSR writes coming back from the CSR read/modify/write unit.
//
// Optional feature (macro URV_TRAP_TIMER_EN):
//   Adds a 32-bit down-counter (mtimer, custom CSR 0x7C0) that raises a
//   sticky MTIP when it counts 1 -> 0. Writing the CSR reloads the counter
//   and clears MTIP. The current count is exported on csr_mtimer_o, which
//   only exists when the macro is defined. Without the macro there is no
//   counter, MTIP reads 0 and writes to 0x7C0 are ignored.
//
// Parameters:
//   IRQ_SYNC_STAGES      flops on irq_i before it reaches mip.MEIP (1..3)
//
// Ports:
//   clk_i                clock
//   rst_i                synchronous reset, active-high
//   x_stall_i            execute stage stalled (nothing commits)
//   x_kill_i             execute instruction squashed (nothing commits)
//   x_is_csr_i           CSR instruction in execute
//   x_csr_sel_i          CSR address of that instruction
//   x_csr_write_value_i  new CSR value produced by the CSR unit
//   x_exception_i        synchronous exception in execute
//   x_exception_cause_i  exception code
//   x_pc_i               PC of the execute instruction
//   x_is_mret_i          MRET in execute
//   irq_i                external interrupt (level, asynchronous)
//   x_trap_o             redirect to the trap vector this cycle
//   x_mret_o             redirect to mepc this cycle
//   csr_mstatus_o        mstatus read value (MIE[3], MPIE[7])
//   csr_mip_o            mip read value (MTIP[7], MEIP[11])
//   csr_mie_o            mie read value (MTIE[7], MEIE[11])
//   csr_mepc_o           mepc read value ([1:0] read 0)
//   csr_mcause_o         mcause read value ([31] interrupt, [3:0] code)
//   csr_mtimer_o         mtimer count (URV_TRAP_TIMER_EN only)
// ============================================================================
module urv_trap_ctrl #(
    parameter int IRQ_SYNC_STAGES = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,

    input  logic        x_stall_i,
    input  logic        x_kill_i,
    input  logic        x_is_csr_i,
    input  logic [11:0] x_csr_sel_i,
    input  logic [31:0] x_csr_write_value_i,
    input  logic        x_exception_i,
    input  logic [3:0]  x_exception_cause_i,
    input  logic [31:0] x_pc_i,
    input  logic        x_is_mret_i,

    input  logic        irq_i,

    output logic        x_trap_o,
    output logic        x_mret_o,

    output logic [31:0] csr_mstatus_o,
    output logic [31:0] csr_mip_o,
    output logic [31:0] csr_mie_o,
    output logic [31:0] csr_mepc_o,
    output logic [31:0] csr_mcause_o
`ifdef URV_TRAP_TIMER_EN
    ,
    output logic [31:0] csr_mtimer_o
`endif
);

    localparam logic [11:0] CSR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_MIE     = 12'h304;
    localparam logic [11:0] CSR_MEPC    = 12'h341;
    localparam logic [11:0] CSR_MCAUSE  = 12'h342;

    localparam logic [3:0]  IRQ_CODE_EXT   = 4'd11;
    localparam logic [3:0]  IRQ_CODE_TIMER = 4'd7;

    // TRAP and MRET each last exactly one cycle: the redirect cycle.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_TRAP = 2'd1,
        ST_MRET = 2'd2
    } state_e;

    state_e state_q, state_d;

    // Architectural state, kept as the implemented bit fields only.
    logic        mstatus_mie_q,  mstatus_mie_d;
    logic        mstatus_mpie_q, mstatus_mpie_d;
    logic        mie_mtie_q,     mie_mtie_d;
    logic        mie_meie_q,     mie_meie_d;
    logic [31:2] mepc_q,         mepc_d;
    logic        mcause_irq_q,   mcause_irq_d;
    logic [3:0]  mcause_code_q,  mcause_code_d;

    logic [IRQ_SYNC_STAGES-1:0] irq_sync_q, irq_sync_d;

    logic mip_meip;
    logic mip_mtip;

    logic commit;
    logic in_idle;
    logic ext_pend;
    logic tmr_pend;
    logic irq_pend;
    logic take_exc;
    logic take_irq;
    logic take_trap;
    logic take_mret;
    logic csr_wr;

    // mepc is word aligned, so the low PC bits are never stored.
    logic unused_pc_bits;
    assign unused_pc_bits = ^x_pc_i[1:0];

    // ------------------------------------------------------------------
    // Event decode
    // ------------------------------------------------------------------
    assign commit   = !x_stall_i && !x_kill_i;
    assign in_idle  = (state_q == ST_IDLE);

    assign mip_meip = irq_sync_q[IRQ_SYNC_STAGES-1];
    assign ext_pend = mip_meip && mie_meie_q;
    assign tmr_pend = mip_mtip && mie_mtie_q;
    assign irq_pend = mstatus_mie_q && (ext_pend || tmr_pend);

    // Only an IDLE commit cycle may act. During the one-cycle redirect the
    // instruction in execute is being flushed, so it must not start a new
    // trap, retire an MRET or write a CSR.
    assign take_exc  = in_idle && commit && x_exception_i;
    assign take_irq  = in_idle && commit && !x_exception_i && irq_pend;
    assign take_trap = take_exc || take_irq;
    assign take_mret = in_idle && commit && !take_trap && x_is_mret_i;
    assign csr_wr    = in_idle && commit && !take_trap && !take_mret && x_is_csr_i;

    // ------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        state_d = ST_IDLE;
        unique case (state_q)
            ST_IDLE: begin
                if (take_trap) begin
                    state_d = ST_TRAP;
                end else if (take_mret) begin
                    state_d = ST_MRET;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_TRAP: state_d = ST_IDLE;
            ST_MRET: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Redirects are gated by reset so a reset landing on the redirect cycle
    // suppresses it immediately instead of one cycle later.
    assign x_trap_o = (state_q == ST_TRAP) && !rst_i;
    assign x_mret_o = (state_q == ST_MRET) && !rst_i;

    // ------------------------------------------------------------------
    // CSR next state: trap > MRET > CSR write
    // ------------------------------------------------------------------
    always_comb begin
        mstatus_mie_d  = mstatus_mie_q;
        mstatus_mpie_d = mstatus_mpie_q;
        mie_mtie_d     = mie_mtie_q;
        mie_meie_d     = mie_meie_q;
        mepc_d         = mepc_q;
        mcause_irq_d   = mcause_irq_q;
        mcause_code_d  = mcause_code_q;

        if (take_trap) begin
            mepc_d         = x_pc_i[31:2];
            mstatus_mpie_d = mstatus_mie_q;
            mstatus_mie_d  = 1'b0;
            if (take_exc) begin
                mcause_irq_d  = 1'b0;
                mcause_code_d = x_exception_cause_i;
            end else begin
                mcause_irq_d  = 1'b1;
                mcause_code_d = ext_pend ? IRQ_CODE_EXT : IRQ_CODE_TIMER;
            end
        end else if (take_mret) begin
            mstatus_mie_d  = mstatus_mpie_q;
            mstatus_mpie_d = 1'b1;
        end else if (csr_wr) begin
            // mip is read-only and unknown addresses are ignored; the timer
            // CSR is handled in its own block below.
            case (x_csr_sel_i)
                CSR_MSTATUS: begin
                    mstatus_mie_d  = x_csr_write_value_i[3];
                    mstatus_mpie_d = x_csr_write_value_i[7];
                end
                CSR_MIE: begin
                    mie_mtie_d = x_csr_write_value_i[7];
                    mie_meie_d = x_csr_write_value_i[11];
                end
                CSR_MEPC: begin
                    mepc_d = x_csr_write_value_i[31:2];
                end
                CSR_MCAUSE: begin
                    mcause_irq_d  = x_csr_write_value_i[31];
                    mcause_code_d = x_csr_write_value_i[3:0];
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mstatus_mie_q  <= 1'b0;
            mstatus_mpie_q <= 1'b0;
            mie_mtie_q     <= 1'b0;
            mie_meie_q     <= 1'b0;
            mepc_q         <= '0;
            mcause_irq_q   <= 1'b0;
            mcause_code_q  <= '0;
        end else begin
            mstatus_mie_q  <= mstatus_mie_d;
            mstatus_mpie_q <= mstatus_mpie_d;
            mie_mtie_q     <= mie_mtie_d;
            mie_meie_q     <= mie_meie_d;
            mepc_q         <= mepc_d;
            mcause_irq_q   <= mcause_irq_d;
            mcause_code_q  <= mcause_code_d;
        end
    end

    // ------------------------------------------------------------------
    // External interrupt synchroniser; the last stage is MEIP itself, so
    // MEIP follows the source level and is never cleared by software.
    // ------------------------------------------------------------------
    always_comb begin
        irq_sync_d    = irq_sync_q;
        irq_sync_d[0] = irq_i;
        for (int i = 1; i < IRQ_SYNC_STAGES; i++) begin
            irq_sync_d[i] = irq_sync_q[i-1];
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            irq_sync_q <= '0;
        end else begin
            irq_sync_q <= irq_sync_d;
        end
    end

    // ------------------------------------------------------------------
    // Optional machine timer
    // ------------------------------------------------------------------
`ifdef URV_TRAP_TIMER_EN
    localparam logic [11:0] CSR_MTIMER = 12'h7C0;

    logic [31:0] mtimer_q, mtimer_d;
    logic        mtip_q,   mtip_d;

    // Free-running: the counter keeps decrementing through stalls. MTIP is
    // sticky once the count reaches zero and only a write clears it; a
    // write of 0 leaves the counter idle without raising MTIP.
    always_comb begin
        mtimer_d = mtimer_q;
        mtip_d   = mtip_q;
        if (csr_wr && (x_csr_sel_i == CSR_MTIMER)) begin
            mtimer_d = x_csr_write_value_i;
            mtip_d   = 1'b0;
        end else if (mtimer_q != 32'd0) begin
            mtimer_d = mtimer_q - 32'd1;
            if (mtimer_q == 32'd1) begin
                mtip_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mtimer_q <= '0;
            mtip_q   <= 1'b0;
        end else begin
            mtimer_q <= mtimer_d;
            mtip_q   <= mtip_d;
        end
    end

    assign mip_mtip     = mtip_q;
    assign csr_mtimer_o = mtimer_q;
`else
    assign mip_mtip = 1'b0;
`endif

    // ------------------------------------------------------------------
    // CSR read values
    // ------------------------------------------------------------------
    assign csr_mstatus_o = {24'd0, mstatus_mpie_q, 3'd0, mstatus_mie_q, 3'd0};
    assign csr_mie_o     = {20'd0, mie_meie_q, 3'd0, mie_mtie_q, 7'd0};
    assign csr_mip_o     = {20'd0, mip_meip, 3'd0, mip_mtip, 7'd0};
    assign csr_mepc_o    = {mepc_q, 2'b00};
    assign csr_mcause_o  = {mcause_irq_q, 27'd0, mcause_code_q};

endmodule

// File: tb/tb_urv_trap_ctrl.sv
// Self-checking bench for urv_trap_ctrl: directed scenarios followed by a
// randomized run compared against a behavioural model of the trap rules.
module tb_urv_trap_ctrl;

    localparam int S = 2;
`ifdef URV_TRAP_TIMER_EN
    localparam bit TIMER_EN = 1'b1;
`else
    localparam bit TIMER_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        stall, kill, is_csr, exc, mret, irq;
    logic [11:0] csr_sel;
    logic [31:0] csr_wv, pc;
    logic [3:0]  cause;
    logic        x_trap, x_mret;
    logic [31:0] mstatus, mip, mie, mepc, mcause;
`ifdef URV_TRAP_TIMER_EN
    logic [31:0] mtimer;
`endif

    int checks = 0;
    int errors = 0;

    urv_trap_ctrl #(.IRQ_SYNC_STAGES(S)) dut (
        .clk_i               (clk),
        .rst_i               (rst),
        .x_stall_i           (stall),
        .x_kill_i            (kill),
        .x_is_csr_i          (is_csr),
        .x_csr_sel_i         (csr_sel),
        .x_csr_write_value_i (csr_wv),
        .x_exception_i       (exc),
        .x_exception_cause_i (cause),
        .x_pc_i              (pc),
        .x_is_mret_i         (mret),
        .irq_i               (irq),
        .x_trap_o            (x_trap),
        .x_mret_o            (x_mret),
        .csr_mstatus_o       (mstatus),
        .csr_mip_o           (mip),
        .csr_mie_o           (mie),
        .csr_mepc_o          (mepc),
        .csr_mcause_o        (mcause)
`ifdef URV_TRAP_TIMER_EN
        ,
        .csr_mtimer_o        (mtimer)
`endif
    );

    always #5 clk = ~clk;

    // ---------------- reference model state ----------------
    bit        m_st_mie, m_st_mpie, m_trap, m_mret, m_mtip;
    bit [31:0] m_mie_csr, m_mepc, m_mcause, m_tmr;
    bit        irq_hist[$];

    string       nm[7] = '{"x_trap", "x_mret", "mstatus", "mie", "mip", "mepc", "mcause"};
    logic [31:0] got[7];
    logic [31:0] want[7];
    logic [11:0] pool[7] = '{12'h300, 12'h304, 12'h341, 12'h342, 12'h344, 12'h7C0, 12'h123};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        stall = 0; kill = 0; is_csr = 0; csr_sel = '0; csr_wv = '0;
        exc = 0; cause = '0; pc = '0; mret = 0;
    endtask

    task automatic do_reset();
        rst = 1; clear_inputs(); irq = 0;
        tick();
        rst = 0;
    endtask

    task automatic csr_write(input logic [11:0] a, input logic [31:0] v);
        is_csr = 1; csr_sel = a; csr_wv = v;
        tick();
        is_csr = 0;
    endtask

    // One clock edge of the architectural rules, applied to the inputs
    // that were stable across that edge. irq_hist[0] is the visible MEIP.
    task automatic model_edge();
        bit nt, nm_r, twr, ext, tmr;
        if (rst) begin
            m_st_mie = 0; m_st_mpie = 0; m_mie_csr = 0; m_mepc = 0; m_mcause = 0;
            m_tmr = 0; m_mtip = 0; m_trap = 0; m_mret = 0;
            irq_hist.delete();
            for (int i = 0; i < S; i++) irq_hist.push_back(1'b0);
            return;
        end
        nt = 0; nm_r = 0; twr = 0;
        ext = irq_hist[0] && m_mie_csr[11];
        tmr = m_mtip && m_mie_csr[7];
        if (!(m_trap || m_mret) && !stall && !kill) begin
            if (exc) begin
                nt = 1; m_mcause = {28'd0, cause};
            end else if (m_st_mie && (ext || tmr)) begin
                nt = 1; m_mcause = ext ? 32'h8000000B : 32'h80000007;
            end else if (mret) begin
                nm_r = 1; m_st_mie = m_st_mpie; m_st_mpie = 1;
            end else if (is_csr) begin
                case (csr_sel)
                    12'h300: begin m_st_mie = csr_wv[3]; m_st_mpie = csr_wv[7]; end
                    12'h304: m_mie_csr = csr_wv & 32'h0000_0880;
                    12'h341: m_mepc    = csr_wv & 32'hFFFF_FFFC;
                    12'h342: m_mcause  = csr_wv & 32'h8000_000F;
                    12'h7C0: twr = TIMER_EN;
                    default: ;
                endcase
            end
            if (nt) begin
                m_mepc = pc & 32'hFFFF_FFFC; m_st_mpie = m_st_mie; m_st_mie = 0;
            end
        end
        if (twr) begin
            m_tmr = csr_wv; m_mtip = 0;
        end else if (m_tmr != 0) begin
            m_tmr = m_tmr - 1;
            if (m_tmr == 0) m_mtip = 1;
        end
        irq_hist.push_back(irq);
        void'(irq_hist.pop_front());
        m_trap = nt; m_mret = nm_r;
    endtask

    // ---------------- directed scenarios ----------------
    task automatic test_reset();
        rst = 1; clear_inputs(); irq = 0;
        tick(); tick();
        got = '{{31'd0, x_trap}, {31'd0, x_mret}, mstatus, mie, mip, mepc, mcause};
        for (int k = 0; k < 7; k++) begin
            checks++;
            if (got[k] !== 32'd0) begin
                errors++;
                $display("FAIL reset_%s got %08h want 00000000", nm[k], got[k]);
            end
        end
        rst = 0;
    endtask

    task automatic test_exception();
        do_reset();
        csr_write(12'h300, 32'h8);
        checks++; if (mstatus !== 32'h8) begin errors++; $display("FAIL exc_mstatus_setup got %08h want 00000008", mstatus); end
        exc = 1; cause = 4'd2; pc = 32'h100;
        tick();
        exc = 0;
        checks++; if (x_trap !== 1'b1) begin errors++; $display("FAIL exc_trap got %0b want 1", x_trap); end
        checks++; if (mepc !== 32'h100) begin errors++; $display("FAIL exc_mepc got %08h want 00000100", mepc); end
        checks++; if (mcause !== 32'h2) begin errors++; $display("FAIL exc_mcause got %08h want 00000002", mcause); end
        checks++; if (mstatus !== 32'h80) begin errors++; $display("FAIL exc_mstatus got %08h want 00000080", mstatus); end
        tick();
        checks++; if (x_trap !== 1'b0) begin errors++; $display("FAIL exc_trap_pulse got %0b want 0", x_trap); end
    endtask

    task automatic test_irq();
        do_reset();
        csr_write(12'h304, 32'h800);
        csr_write(12'h300, 32'h8);
        irq = 1;
        for (int i = 0; i < S - 1; i++) tick();
        checks++; if (mip !== 32'h0) begin errors++; $display("FAIL irq_sync_early got %08h want 00000000", mip); end
        tick();
        checks++; if (mip !== 32'h800) begin errors++; $display("FAIL irq_meip got %08h want 00000800", mip); end
        checks++; if (x_trap !== 1'b0) begin errors++; $display("FAIL irq_trap_early got %0b want 0", x_trap); end
        tick();
        checks++; if (x_trap !== 1'b1) begin errors++; $display("FAIL irq_trap got %0b want 1", x_trap); end
        checks++; if (mcause !== 32'h8000000B) begin errors++; $display("FAIL irq_mcause got %08h want 8000000b", mcause); end
        checks++; if (mstatus !== 32'h80) begin errors++; $display("FAIL irq_mstatus got %08h want 00000080", mstatus); end
        irq = 0;
    endtask

    task automatic test_irq_stall();
        int seen;
        do_reset();
        csr_write(12'h304, 32'h800);
        csr_write(12'h300, 32'h8);
        stall = 1; irq = 1; seen = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (x_trap) seen++;
        end
        checks++; if (seen !== 0) begin errors++; $display("FAIL stall_no_trap got %0d traps want 0", seen); end
        checks++; if (mip !== 32'h800) begin errors++; $display("FAIL stall_mip got %08h want 00000800", mip); end
        checks++; if (mstatus !== 32'h8) begin errors++; $display("FAIL stall_mstatus got %08h want 00000008", mstatus); end
        stall = 0;
        tick();
        checks++; if (x_trap !== 1'b1) begin errors++; $display("FAIL stall_release_trap got %0b want 1", x_trap); end
        checks++; if (mcause !== 32'h8000000B) begin errors++; $display("FAIL stall_mcause got %08h want 8000000b", mcause); end
        irq = 0;
    endtask

    task automatic test_simultaneous();
        do_reset();
        csr_write(12'h304, 32'h800);
        irq = 1;
        for (int i = 0; i < S; i++) tick();
        csr_write(12'h300, 32'h8);
        exc = 1; cause = 4'd5; pc = 32'h200;
        is_csr = 1; csr_sel = 12'h300; csr_wv = 32'h8;
        tick();
        checks++; if (x_trap !== 1'b1) begin errors++; $display("FAIL simul_trap got %0b want 1", x_trap); end
        checks++; if (mcause !== 32'h5) begin errors++; $display("FAIL simul_mcause got %08h want 00000005", mcause); end
        checks++; if (mepc !== 32'h200) begin errors++; $display("FAIL simul_mepc got %08h want 00000200", mepc); end
        checks++; if (mstatus !== 32'h80) begin errors++; $display("FAIL simul_mstatus got %08h want 00000080", mstatus); end
        // Same requests held through the redirect cycle must be ignored.
        cause = 4'd3; pc = 32'h300;
        tick();
        clear_inputs();
        checks++; if (x_trap !== 1'b0) begin errors++; $display("FAIL redirect_no_retrap got %0b want 0", x_trap); end
        checks++; if (mcause !== 32'h5) begin errors++; $display("FAIL redirect_mcause got %08h want 00000005", mcause); end
        checks++; if (mepc !== 32'h200) begin errors++; $display("FAIL redirect_mepc got %08h want 00000200", mepc); end
        checks++; if (mstatus !== 32'h80) begin errors++; $display("FAIL redirect_mstatus got %08h want 00000080", mstatus); end
        irq = 0;
    endtask

    task automatic test_mret();
        do_reset();
        csr_write(12'h300, 32'h80);
        kill = 1; mret = 1;
        tick();
        checks++; if (x_mret !== 1'b0) begin errors++; $display("FAIL mret_killed got %0b want 0", x_mret); end
        checks++; if (mstatus !== 32'h80) begin errors++; $display("FAIL mret_killed_mstatus got %08h want 00000080", mstatus); end
        kill = 0;
        tick();
        mret = 0;
        checks++; if (x_mret !== 1'b1) begin errors++; $display("FAIL mret_pulse got %0b want 1", x_mret); end
        checks++; if (mstatus !== 32'h88) begin errors++; $display("FAIL mret_mstatus got %08h want 00000088", mstatus); end
        tick();
        checks++; if (x_mret !== 1'b0) begin errors++; $display("FAIL mret_pulse_end got %0b want 0", x_mret); end
    endtask

    task automatic test_csr_masks();
        do_reset();
        csr_write(12'h300, 32'hFFFF_FFFF);
        checks++; if (mstatus !== 32'h88) begin errors++; $display("FAIL mask_mstatus got %08h want 00000088", mstatus); end
        csr_write(12'h304, 32'hFFFF_FFFF);
        checks++; if (mie !== 32'h880) begin errors++; $display("FAIL mask_mie got %08h want 00000880", mie); end
        csr_write(12'h344, 32'hFFFF_FFFF);
        checks++; if (mip !== 32'h0) begin errors++; $display("FAIL mask_mip_ro got %08h want 00000000", mip); end
        csr_write(12'h341, 32'hFFFF_FFFF);
        checks++; if (mepc !== 32'hFFFF_FFFC) begin errors++; $display("FAIL mask_mepc got %08h want fffffffc", mepc); end
        csr_write(12'h342, 32'hFFFF_FFFF);
        checks++; if (mcause !== 32'h8000_000F) begin errors++; $display("FAIL mask_mcause got %08h want 8000000f", mcause); end
        stall = 1;
        csr_write(12'h341, 32'h40);
        stall = 0;
        checks++; if (mepc !== 32'hFFFF_FFFC) begin errors++; $display("FAIL stalled_write got %08h want fffffffc", mepc); end
        kill = 1;
        csr_write(12'h342, 32'h0);
        kill = 0;
        checks++; if (mcause !== 32'h8000_000F) begin errors++; $display("FAIL killed_write got %08h want 8000000f", mcause); end
    endtask

    task automatic test_timer();
        logic [31:0] want_mip, want_cause;
        logic        want_trap;
        want_mip   = TIMER_EN ? 32'h80 : 32'h0;
        want_cause = TIMER_EN ? 32'h8000_0007 : 32'h0;
        want_trap  = TIMER_EN;
        do_reset();
        csr_write(12'h7C0, 32'd5);
        csr_write(12'h304, 32'h80);
        csr_write(12'h300, 32'h8);
        tick(); tick();
        checks++; if (mip !== 32'h0) begin errors++; $display("FAIL timer_early got %08h want 00000000", mip); end
        tick();
        checks++; if (mip !== want_mip) begin errors++; $display("FAIL timer_mtip got %08h want %08h", mip, want_mip); end
        tick();
        checks++; if (x_trap !== want_trap) begin errors++; $display("FAIL timer_trap got %0b want %0b", x_trap, want_trap); end
        checks++; if (mcause !== want_cause) begin errors++; $display("FAIL timer_mcause got %08h want %08h", mcause, want_cause); end
        tick();
        csr_write(12'h7C0, 32'd0);
        checks++; if (mip !== 32'h0) begin errors++; $display("FAIL timer_clear got %08h want 00000000", mip); end
    endtask

    task automatic test_reset_mid_trap();
        do_reset();
        csr_write(12'h304, 32'h880);
        exc = 1; cause = 4'd4; pc = 32'h44;
        tick();
        exc = 0;
        checks++; if (x_trap !== 1'b1) begin errors++; $display("FAIL rstmid_trap got %0b want 1", x_trap); end
        checks++; if (mepc !== 32'h44) begin errors++; $display("FAIL rstmid_mepc got %08h want 00000044", mepc); end
        rst = 1;
        #1;
        checks++; if (x_trap !== 1'b0) begin errors++; $display("FAIL rstmid_trap_drop got %0b want 0", x_trap); end
        tick();
        got = '{{31'd0, x_trap}, {31'd0, x_mret}, mstatus, mie, mip, mepc, mcause};
        for (int k = 0; k < 7; k++) begin
            checks++;
            if (got[k] !== 32'd0) begin
                errors++;
                $display("FAIL rstmid_%s got %08h want 00000000", nm[k], got[k]);
            end
        end
        rst = 0;
    endtask

    task automatic test_random();
        rst = 1; clear_inputs(); irq = 0;
        tick();
        model_edge();
        rst = 0;
        for (int c = 0; c < 3000; c++) begin
            rst     = ($urandom_range(0, 149) == 0);
            stall   = ($urandom_range(0, 4) == 0);
            kill    = ($urandom_range(0, 7) == 0);
            exc     = ($urandom_range(0, 9) == 0);
            cause   = 4'($urandom);
            pc      = $urandom;
            mret    = ($urandom_range(0, 7) == 0);
            is_csr  = ($urandom_range(0, 2) == 0);
            csr_sel = pool[$urandom_range(0, 6)];
            csr_wv  = (csr_sel == 12'h7C0) ? 32'($urandom_range(0, 12)) : $urandom;
            if ($urandom_range(0, 15) == 0) irq = ~irq;
            tick();
            model_edge();
            got  = '{{31'd0, x_trap}, {31'd0, x_mret}, mstatus, mie, mip, mepc, mcause};
            want = '{{31'd0, m_trap}, {31'd0, m_mret},
                     {24'd0, m_st_mpie, 3'd0, m_st_mie, 3'd0}, m_mie_csr,
                     {20'd0, irq_hist[0], 3'd0, m_mtip, 7'd0}, m_mepc, m_mcause};
            for (int k = 0; k < 7; k++) begin
                checks++;
                if (got[k] !== want[k]) begin
                    errors++;
                    $display("FAIL rand_%s cycle %0d got %08h want %08h", nm[k], c, got[k], want[k]);
                end
            end
        end
        rst = 0; clear_inputs(); irq = 0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1; clear_inputs(); irq = 0;
        test_reset();
        test_exception();
        test_irq();
        test_irq_stall();
        test_simultaneous();
        test_mret();
        test_csr_masks();
        test_timer();
        test_reset_mid_trap();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
